// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file: address
// range check and highest-priority write-port match used by the bypass path.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int MAX_NWRITE = 8;
  localparam int MAX_AW     = 16;

  typedef struct packed {
    logic       hit;
    logic [7:0] idx;
  } wr_match_t;

  function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs);
    return (addr < nregs);
  endfunction

  // Ports are scanned upward so the highest matching index is the one returned.
  function automatic wr_match_t wr_match(input logic [MAX_NWRITE-1:0]        we,
                                         input logic [MAX_NWRITE*MAX_AW-1:0] wa,
                                         input logic [MAX_AW-1:0]            addr);
    wr_match_t r;
    r.hit = 1'b0;
    r.idx = 8'd0;
    for (int i = 0; i < MAX_NWRITE; i++) begin
      if (we[i] && (wa[i*MAX_AW +: MAX_AW] == addr)) begin
        r.hit = 1'b1;
        r.idx = 8'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register, out-of-range, bypass and
// array selection plus operand-ready derivation from the busy scoreboard.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic [AW-1:0]          ra,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic [NREGS*XLEN-1:0]  regs,
  input  logic [NREGS-1:0]       busy,
  output logic [XLEN-1:0]        rd,
  output logic                   rd_ready
);

  logic [MAX_NWRITE-1:0]        we_ext_s;
  logic [MAX_NWRITE*MAX_AW-1:0] wa_ext_s;
  wr_match_t                    match_s;
  int unsigned                  ra_int_s;

  always_comb begin
    we_ext_s = '0;
    wa_ext_s = '0;
    for (int i = 0; i < NWRITE; i++) begin
      we_ext_s[i]                       = we[i];
      wa_ext_s[i*MAX_AW +: MAX_AW]      = MAX_AW'(wa[i*AW +: AW]);
    end
  end

  assign match_s  = wr_match(we_ext_s, wa_ext_s, MAX_AW'(ra));
  assign ra_int_s = 32'(ra);

  // Zero register and out-of-range addresses are never pending.
  always_comb begin
    rd       = '0;
    rd_ready = 1'b1;
    if ((ZERO_REG != 0) && (ra == '0)) begin
      rd       = '0;
      rd_ready = 1'b1;
    end else if (!addr_valid(ra_int_s, 32'(NREGS))) begin
      rd       = '0;
      rd_ready = 1'b1;
    end else if ((BYPASS != 0) && match_s.hit) begin
      rd       = wd[32'(match_s.idx)*XLEN +: XLEN];
      rd_ready = 1'b1;
    end else begin
      rd       = regs[ra_int_s*XLEN +: XLEN];
      rd_ready = !busy[ra_int_s];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read / M-write integer register file with optional
// hardwired zero register, write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*XLEN-1:0]  rd,
  output logic [NREAD-1:0]       rd_ready,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic [NREGS-1:0]       busy
);

  logic [XLEN-1:0]       mem_q [NREGS];
  logic [XLEN-1:0]       mem_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [NREGS*XLEN-1:0] regs_flat_s;

  // Later write ports overwrite earlier ones; a busy set lands after the clears.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i] && addr_valid(32'(wa[i*AW +: AW]), 32'(NREGS))) begin
        busy_d[wa[i*AW +: AW]] = 1'b0;
        if (!((ZERO_REG != 0) && (wa[i*AW +: AW] == '0))) begin
          mem_d[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
        end else begin
          mem_d[wa[i*AW +: AW]] = mem_q[wa[i*AW +: AW]];
        end
      end else begin
        busy_d = busy_d;
      end
    end
    if (sb_set && addr_valid(32'(sb_addr), 32'(NREGS)) &&
        !((ZERO_REG != 0) && (sb_addr == '0))) begin
      busy_d[sb_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Synchronous reset overrides any same-cycle write or busy set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_flat_s[k*XLEN +: XLEN] = mem_q[k];
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rport
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .AW       (AW)
    ) u_rport (
      .ra       (ra[j*AW +: AW]),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .regs     (regs_flat_s),
      .busy     (busy_q),
      .rd       (rd[j*XLEN +: XLEN]),
      .rd_ready (rd_ready[j])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_ready;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .rd_ready (rd_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ra = '0; we = '0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0;
    step();
    rst_n = 1'b1;
    ra = {5'd31, 5'd0};
    #1;
    chk("rst_rd",    64'(rd),       64'd0);
    chk("rst_ready", 64'(rd_ready), 64'd3);
    chk("rst_busy",  64'(busy),     64'd0);

    // basic write, visible via bypass then via array
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd8, 5'd5};
    #1;
    chk("byp_wr5",   64'(rd[31:0]),  64'hDEADBEEF);
    chk("other_rd8", 64'(rd[63:32]), 64'd0);
    step();
    we = 2'b00;
    #1;
    chk("arr_rd5",   64'(rd[31:0]),  64'hDEADBEEF);

    // writes to reg 0 are dropped
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFFFFFF}; ra = {5'd5, 5'd0};
    #1;
    chk("zero_byp",  64'(rd[31:0]),  64'd0);
    step();
    we = 2'b00;
    #1;
    chk("zero_arr",  64'(rd[31:0]),  64'd0);
    chk("rd5_port1", 64'(rd[63:32]), 64'hDEADBEEF);

    // same-address dual write: port 1 wins
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'd2, 32'd1}; ra = {5'd7, 5'd7};
    #1;
    chk("prio_byp0", 64'(rd[31:0]),  64'd2);
    chk("prio_byp1", 64'(rd[63:32]), 64'd2);
    step();
    we = 2'b00;
    #1;
    chk("prio_arr",  64'(rd[31:0]),  64'd2);

    // scoreboard set, then cleared by a bypassed write
    sb_set = 1'b1; sb_addr = 5'd9;
    step();
    sb_set = 1'b0; ra = {5'd7, 5'd9};
    #1;
    chk("busy9_set",  64'(busy[9]),     64'd1);
    chk("ready_busy", 64'(rd_ready),    64'd2);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h55};
    #1;
    chk("ready_byp",  64'(rd_ready[0]), 64'd1);
    chk("rd_byp9",    64'(rd[31:0]),    64'h55);
    step();
    we = 2'b00;
    #1;
    chk("busy9_clr",  64'(busy[9]),     64'd0);
    chk("rd9_arr",    64'(rd[31:0]),    64'h55);

    // set and clear collide: set wins
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    sb_set = 1'b0;
    #1;
    chk("busy3_set",  64'(busy[3]), 64'd1);
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'hAA}; sb_set = 1'b1; sb_addr = 5'd3;
    step();
    we = 2'b00; sb_set = 1'b0; ra = {5'd0, 5'd3};
    #1;
    chk("coll_rd3",    64'(rd[31:0]),    64'hAA);
    chk("coll_busy3",  64'(busy[3]),     64'd1);
    chk("coll_ready",  64'(rd_ready[0]), 64'd0);
    chk("zero_ready",  64'(rd_ready[1]), 64'd1);

    // busy set on reg 0 is ignored
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    sb_set = 1'b1; sb_addr = 5'd4;
    #1;
    chk("busy0_ign",  64'(busy), 64'h8);
    step();
    sb_set = 1'b0;
    #1;
    chk("busy_34",    64'(busy), 64'h18);

    // reset wins over a concurrent write
    rst_n = 1'b0; we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'd9};
    step();
    rst_n = 1'b1; we = 2'b00; ra = {5'd7, 5'd4};
    #1;
    chk("mrst_rd4",   64'(rd[31:0]),  64'd0);
    chk("mrst_rd7",   64'(rd[63:32]), 64'd0);
    chk("mrst_busy",  64'(busy),      64'd0);
    chk("mrst_ready", 64'(rd_ready),  64'd3);
    ra = {5'd3, 5'd5};
    #1;
    chk("mrst_rd35",  rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core. It is the next generation of the 2-read/1-write RegFile, generalised to N read ports and M write ports. New over the old block: optional hardwired-zero register, same-cycle write-to-read bypass, synchronous reset of all state, and a per-register busy scoreboard for in-flight writebacks. It sits between decode (reads, busy marking) and writeback (writes, busy clearing).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (need not be a power of 2)
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; higher index has higher priority
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and busy-set
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports
AW, $clog2(NREGS), address width (derived, do not override)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
ra  in  NREAD*AW  packed read addresses; port j = ra[j*AW +: AW]
rd  out  NREAD*XLEN  packed read data, combinational
rd_ready  out  NREAD  port j operand not pending (not busy, or bypassed)
we  in  NWRITE  write enables
wa  in  NWRITE*AW  packed write addresses
wd  in  NWRITE*XLEN  packed write data
sb_set  in  1  mark sb_addr busy (instruction issued with this destination)
sb_addr  in  AW  destination register to mark busy
busy  out  NREGS  registered busy vector, bit i = register i pending

Behaviour:
- Reset: rising edge with rst_n=0 clears all registers to 0 and busy to 0. While rst_n=0, we and sb_set are ignored. A reset in the same cycle as a write or set means reset wins. After reset every rd reads 0 and every rd_ready is 1.
- Write: at rising edge, for each i with we[i]=1 and a valid address, reg[wa_i] <= wd_i. Writes to reg 0 are dropped when ZERO_REG=1. If several ports target the same address, the highest index wins.
- Read: combinational with zero cycles of latency.
  - ZERO_REG=1 and ra_j=0 -> rd_j=0.
  - Otherwise, if BYPASS=1 and some we[i] has wa_i==ra_j, rd_j = wd of the highest such i.
  - Otherwise rd_j = reg[ra_j].
  - With BYPASS=0, rd_j reflects the new value only from the cycle after the write.
- Out-of-range address (>= NREGS): reads return 0 with rd_ready=1; writes and sets are ignored.
- Scoreboard:
  - At rising edge, a write on any port to address a clears busy[a].
  - sb_set=1 sets busy[sb_addr]. A set to reg 0 is ignored when ZERO_REG=1.
  - If a set and a clear hit the same address in the same cycle, the set wins and busy stays 1 (a new producer was issued).
- rd_ready_j = !busy[ra_j] | (BYPASS & any we[i] with wa_i==ra_j). It is always 1 for reg 0 when ZERO_REG=1.
- All outputs are free of X after the first reset edge. Simultaneous reads of the same address on several ports return identical data.

Decomposition:
- Shared package regfile_pkg holds:
  - the default XLEN and NREGS constants;
  - a function for the address-valid check;
  - a function for highest-priority write-port match, returning hit and index.
- One sub-module, regfile_read_port, is instantiated NREAD times. It contains the zero/bypass/array mux and the rd_ready logic for one port.
- The storage array and scoreboard stay in regfile_mp.

Test Plan:
- Reset then read: rst_n=0 for 1 edge, then ra={0,31} -> rd={0,0}, rd_ready=2'b11, busy=0.
- Basic write/read: we[0]=1, wa0=5, wd0=32'hDEADBEEF; next cycle ra0=5 -> rd0=32'hDEADBEEF. Write reg 0 with 32'hFFFFFFFF -> ra=0 still reads 0.
- Bypass and priority: in the same cycle, we=2'b11, wa0=wa1=7, wd0=1, wd1=2, and ra0=7 -> rd0=2 combinationally (BYPASS=1). Next cycle reg7 reads 2.
- Scoreboard: sb_set=1, sb_addr=9 -> busy[9]=1 and rd_ready=0 for ra=9.
  - A later write to 9 with 32'h55 -> rd_ready=1 in that cycle with rd=32'h55 via bypass; busy[9]=0 after the edge.
- Set/clear collision: busy[3]=1, then in one cycle we[0]=1, wa0=3 and sb_set=1, sb_addr=3 -> reg3 updated, busy[3] remains 1.
- Reset mid-operation: with regs written and busy[4]=1, assert rst_n=0 together with we=1, wa=4, wd=9 -> after the edge reg4=0 and busy=0.
